// File: rtl/usr_serial_deserializer.sv
// Framed serial-to-parallel receiver for the universal shift register's serial output.
// Define USR_DESER_PARITY_EN to expect an even-parity bit after the data bits.
module usr_serial_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             dir,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             q_perr,
    output logic             busy,
    output logic             ovr
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] q_data_q, q_data_d;
    logic             q_valid_q, q_valid_d;
    logic             q_perr_q, q_perr_d;
    logic             ovr_q, ovr_d;

    logic             deliver;
    logic [WIDTH-1:0] word;
    logic             word_perr;
    logic [WIDTH-1:0] shifted;

`ifdef USR_DESER_PARITY_EN
    function automatic logic even_parity_err(input logic [WIDTH-1:0] w, input logic p);
        return (^w) ^ p;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        q_data_d  = q_data_q;
        q_valid_d = q_valid_q;
        q_perr_d  = q_perr_q;
        ovr_d     = ovr_q;
        deliver   = 1'b0;
        word      = shreg_q;
        word_perr = 1'b0;
        shifted   = dir_q ? {shreg_q[WIDTH-2:0], s_in} : {s_in, shreg_q[WIDTH-1:1]};

        if (q_valid_q && q_ready) begin
            q_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_valid && s_in) begin
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (s_valid) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef USR_DESER_PARITY_EN
                        state_d = PARITY;
`else
                        deliver = 1'b1;
                        word    = shifted;
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef USR_DESER_PARITY_EN
            PARITY: begin
                if (s_valid) begin
                    deliver   = 1'b1;
                    word      = shreg_q;
                    word_perr = even_parity_err(shreg_q, s_in);
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A word that arrives while the previous one is still held and not being taken is dropped.
        if (deliver) begin
            if (!q_valid_q || q_ready) begin
                q_data_d  = word;
                q_perr_d  = word_perr;
                q_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            q_data_q  <= '0;
            q_valid_q <= 1'b0;
            q_perr_q  <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            q_data_q  <= q_data_d;
            q_valid_q <= q_valid_d;
            q_perr_q  <= q_perr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign q_data  = q_data_q;
    assign q_valid = q_valid_q;
    assign q_perr  = q_perr_q;
    assign busy    = (state_q != IDLE);
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_usr_serial_deserializer.sv
// Directed bench for usr_serial_deserializer (WIDTH=4); follows USR_DESER_PARITY_EN if defined.
module tb_usr_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_in = 1'b0;
    logic       s_valid = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] q_data;
    logic       q_valid;
    logic       q_ready = 1'b0;
    logic       q_perr;
    logic       busy;
    logic       ovr;

    int checks = 0;
    int failures = 0;

`ifdef USR_DESER_PARITY_EN
    localparam int PRE_BITS = 4;
`else
    localparam int PRE_BITS = 3;
`endif

    usr_serial_deserializer #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_in   (s_in),
        .s_valid(s_valid),
        .dir    (dir),
        .q_data (q_data),
        .q_valid(q_valid),
        .q_ready(q_ready),
        .q_perr (q_perr),
        .busy   (busy),
        .ovr    (ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        s_valid = 1'b1;
        s_in    = b;
        tick();
        s_valid = 1'b0;
        s_in    = 1'b0;
    endtask

    // Idle cycles with s_valid low; s_in wiggles to show it is ignored.
    task automatic gap_cycles(input int n, input bit chk_busy);
        for (int k = 0; k < n; k++) begin
            s_in = 1'($urandom_range(0, 1));
            tick();
            if (chk_busy) check("busy_gap", 32'(busy), 32'd1);
        end
        s_in = 1'b0;
    endtask

    // Sends the start bit and every frame bit except the final one; seq[0] goes out first.
    task automatic send_prefix(input logic d, input logic [3:0] seq, input bit gaps);
        dir = d;
        bit_in(1'b1);
        dir = ~d;
        for (int i = 0; i < PRE_BITS; i++) begin
            if (gaps) gap_cycles(i % 4, 1'b1);
            bit_in(seq[i]);
        end
    endtask

    function automatic logic final_bit(input logic [3:0] seq, input logic want_perr);
`ifdef USR_DESER_PARITY_EN
        return (^seq) ^ want_perr;
`else
        return seq[3] | (want_perr & 1'b0);
`endif
    endfunction

    function automatic logic exp_perr(input logic want_perr);
`ifdef USR_DESER_PARITY_EN
        return want_perr;
`else
        return want_perr & 1'b0;
`endif
    endfunction

    task automatic pop();
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        check("pop_valid", 32'(q_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_q_data", 32'(q_data), 32'h0);
        check("rst_q_valid", 32'(q_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_q_perr", 32'(q_perr), 32'd0);

        // LSB-first frame 1,0,1,1
        send_prefix(1'b0, 4'b1101, 1'b0);
        check("lsb_busy_pre", 32'(busy), 32'd1);
        check("lsb_valid_pre", 32'(q_valid), 32'd0);
        bit_in(final_bit(4'b1101, 1'b0));
        check("lsb_valid", 32'(q_valid), 32'd1);
        check("lsb_busy", 32'(busy), 32'd0);
        check("lsb_data", 32'(q_data), 32'hd);
        check("lsb_perr", 32'(q_perr), 32'(exp_perr(1'b0)));
        pop();

        // MSB-first, same bits
        send_prefix(1'b1, 4'b1101, 1'b0);
        bit_in(final_bit(4'b1101, 1'b0));
        check("msb_valid", 32'(q_valid), 32'd1);
        check("msb_data", 32'(q_data), 32'hb);
        pop();

        // Idle line bits, then a frame with s_valid gaps
        for (int k = 0; k < 3; k++) begin
            bit_in(1'b0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        send_prefix(1'b0, 4'b1101, 1'b1);
        gap_cycles(3, 1'b1);
        check("gap_valid_pre", 32'(q_valid), 32'd0);
        bit_in(final_bit(4'b1101, 1'b0));
        check("gap_data", 32'(q_data), 32'hd);
        check("gap_busy", 32'(busy), 32'd0);
        pop();

        // Delivery and transfer on the same edge
        send_prefix(1'b0, 4'b0011, 1'b0);
        bit_in(final_bit(4'b0011, 1'b0));
        check("c_data", 32'(q_data), 32'h3);
        send_prefix(1'b0, 4'b1010, 1'b0);
        q_ready = 1'b1;
        bit_in(final_bit(4'b1010, 1'b0));
        q_ready = 1'b0;
        check("same_edge_valid", 32'(q_valid), 32'd1);
        check("same_edge_data", 32'(q_data), 32'ha);
        check("same_edge_ovr", 32'(ovr), 32'd0);
        pop();

        // Overrun: A held, B dropped
        send_prefix(1'b0, 4'b1101, 1'b0);
        bit_in(final_bit(4'b1101, 1'b0));
        send_prefix(1'b0, 4'b0110, 1'b0);
        bit_in(final_bit(4'b0110, 1'b1));
        check("ovr_data", 32'(q_data), 32'hd);
        check("ovr_valid", 32'(q_valid), 32'd1);
        check("ovr_flag", 32'(ovr), 32'd1);
        check("ovr_perr_kept", 32'(q_perr), 32'(exp_perr(1'b0)));
        pop();
        tick();
        check("ovr_sticky", 32'(ovr), 32'd1);

        // Reset mid-frame, then a clean frame
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_ovr", 32'(ovr), 32'd0);
        dir = 1'b0;
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(q_valid), 32'd0);
        send_prefix(1'b0, 4'b1100, 1'b0);
        bit_in(final_bit(4'b1100, 1'b0));
        check("midrst_data", 32'(q_data), 32'hc);
        check("midrst_ovr", 32'(ovr), 32'd0);
        pop();

        // Parity error requested (constant 0 without the parity build)
        send_prefix(1'b0, 4'b1101, 1'b0);
        bit_in(final_bit(4'b1101, 1'b1));
        check("perr_valid", 32'(q_valid), 32'd1);
        check("perr_data", 32'(q_data), 32'hd);
        check("perr_flag", 32'(q_perr), 32'(exp_perr(1'b1)));
        pop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usr_serial_deserializer.md
Name: usr_serial_deserializer

Overview:
- Receive end of the universal shift register's serial output.
- Collects a framed serial bit stream (start bit, then WIDTH data bits) into a parallel word.
- Bit order is selectable so it matches either shift-right (LSB first) or shift-left (MSB first) transmission.
- Presents the word on a valid/ready output with a one-deep holding register and a sticky overrun flag.

Parameters:
- WIDTH, 4: data bits per frame; must be >= 2.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_in  input  1  serial data bit
- s_valid  input  1  qualifies s_in this cycle; bits are sampled only when high
- dir  input  1  0 = LSB first (shift-right source), 1 = MSB first (shift-left source); sampled with the start bit
- q_data  output  WIDTH  assembled parallel word
- q_valid  output  1  q_data holds an unconsumed word
- q_ready  input  1  consumer accepts q_data when high with q_valid
- q_perr  output  1  parity error for the word in q_data (see Optional Feature)
- busy  output  1  high while a frame is in progress
- ovr  output  1  sticky overrun flag

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE, shift register=0, bit count=0, latched dir=0.
  - q_data=0, q_valid=0, q_perr=0, busy=0, ovr=0.
  - Applies mid-frame: the partial frame is discarded.
- s_valid=0: no state, counter or shift-register change. Output handshake still operates.
- State IDLE (busy=0):
  - s_valid=1 and s_in=1: start bit. Latch dir, clear bit count, go to DATA.
  - s_valid=1 and s_in=0: idle line bit, ignored.
  - A start bit is accepted even while q_valid=1.
- State DATA (busy=1), on each s_valid=1:
  - Latched dir=0: shreg <= {s_in, shreg[WIDTH-1:1]}. The first received bit ends at bit 0.
  - Latched dir=1: shreg <= {shreg[WIDTH-2:0], s_in}. The first received bit ends at bit WIDTH-1.
  - Increment the bit count.
  - On the WIDTH-th bit: without parity, deliver the word and go to IDLE. With parity, go to PARITY.
- Delivery (the edge that samples the final bit):
  - q_data gets the fully shifted word, including the final bit.
  - q_valid=1, visible in the following cycle. Latency = 1 clock after the last bit is sampled.
- Output handshake:
  - Transfer occurs when q_valid & q_ready at an edge. q_valid clears unless a new delivery happens on the same edge.
  - Delivery and transfer on the same edge: the new word loads and q_valid stays 1. No overrun.
  - Delivery while q_valid=1 and q_ready=0: the new word is dropped, q_data/q_perr are unchanged, and ovr is set.
  - ovr clears only on rst.
  - q_data is stable while q_valid=1 and the word has not transferred.
- Bit count width is clog2(WIDTH+1); it never wraps inside a frame.
- A start-pattern bit inside DATA is treated as data; there is no resynchronisation.

Optional Feature:
- Macro: USR_DESER_PARITY_EN.
- Defined:
  - After WIDTH data bits, state PARITY waits for one more s_valid bit.
  - Even parity: q_perr = XOR(data bits, parity bit). Delivery happens on the parity-bit edge, following the same handshake and overrun rules.
  - busy stays high through PARITY.
- Undefined:
  - No PARITY state; delivery happens on the last data bit.
  - q_perr is constant 0; the port is still present.

Test Plan:
- WIDTH=4, dir=0, s_valid stream 1(start),1,0,1,1 -> q_data=4'b1101, q_valid rises the cycle after the last bit, busy falls at the same time.
- Same bits with dir=1 -> q_data=4'b1011.
- Stream 1,1,0,1,1 with 0–3 s_valid=0 cycles between bits, plus leading s_in=0 idle bits -> q_data=4'b1101, busy held high throughout the frame.
- q_ready=0, frame A data 1101, then frame B data 0110 -> q_data stays 1101, ovr=1. Raise q_ready -> one transfer, q_valid=0, ovr still 1 until rst.
- rst pulsed after 2 data bits, then full frame 1,0,0,1,1 -> q_data=4'b1100, ovr=0, no stale bits.
- USR_DESER_PARITY_EN: data 1,0,1,1 with parity bit 1 -> q_data=1101, q_perr=0. Same data with parity bit 0 -> q_perr=1. Without the macro, q_perr stays 0 and delivery happens on the 4th data bit.
